onewire_byte_engine: RTL and testbench



---
 rtl/onewire_byte_engine_if.sv | 34 +++
 rtl/onewire_byte_engine.sv | 133 +++++++++++++
 tb/tb_onewire_byte_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/onewire_byte_engine_if.sv
// Signal bundle between the 1-Wire byte engine and its controller/pad.
// Handshake: start is a one-cycle request, taken on any edge where busy=0 (including the done cycle).
interface onewire_byte_engine_if;
    logic       start;
    logic       rw;
    logic [7:0] tx_byte;
    logic       bus_in;
    logic       drive_low;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;

    modport master (
        output start,
        output rw,
        output tx_byte,
        output bus_in,
        input  drive_low,
        input  busy,
        input  done,
        input  rx_byte
    );

    modport slave (
        input  start,
        input  rw,
        input  tx_byte,
        input  bus_in,
        output drive_low,
        output busy,
        output done,
        output rx_byte
    );
endinterface

// File: rtl/onewire_byte_engine.sv
// Byte-level 1-Wire slot generator: eight LSB-first write/read slots per accepted start.
// Every output is registered; the bus is released immediately on reset.
module onewire_byte_engine #(
    parameter int CLK_PER_US  = 27,
    parameter int T_LOW1_US   = 6,
    parameter int T_LOW0_US   = 60,
    parameter int T_SAMPLE_US = 15,
    parameter int T_SLOT_US   = 70
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onewire_byte_engine_if.slave  ow,
    output logic [1:0]            state_dbg
);
    localparam int LOW1 = T_LOW1_US * CLK_PER_US;
    localparam int LOW0 = T_LOW0_US * CLK_PER_US;
    localparam int SAMP = T_SAMPLE_US * CLK_PER_US;
    localparam int SLOT = T_SLOT_US * CLK_PER_US;
    localparam int CW   = $clog2(SLOT) + 1;

    localparam logic [CW-1:0] LOW1_C      = CW'(LOW1);
    localparam logic [CW-1:0] LOW0_C      = CW'(LOW0);
    localparam logic [CW-1:0] SAMP_LAST_C = CW'(SAMP - 1);
    localparam logic [CW-1:0] SLOT_LAST_C = CW'(SLOT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT_ST = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            rw_q, rw_n;
    logic [7:0]      rx_q, rx_n;
    logic            drive_low_q, drive_low_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;

    // Only a write of a 0 bit holds the bus for the long low time.
    function automatic logic [CW-1:0] low_len(input logic r, input logic b);
        return (!r && !b) ? LOW0_C : LOW1_C;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rw_q        <= 1'b0;
            rx_q        <= '0;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            rw_q        <= rw_n;
            rx_q        <= rx_n;
            drive_low_q <= drive_low_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        rw_n        = rw_q;
        rx_n        = rx_q;
        drive_low_n = drive_low_q;
        busy_n      = busy_q;
        done_n      = 1'b0;

        case (state)
            IDLE, FIN: begin
                if (ow.start) begin
                    // First low cycle is the one right after acceptance.
                    state_n     = SLOT_ST;
                    cnt_n       = '0;
                    bit_idx_n   = '0;
                    shreg_n     = ow.tx_byte;
                    rw_n        = ow.rw;
                    busy_n      = 1'b1;
                    drive_low_n = ('0 < low_len(ow.rw, ow.tx_byte[0]));
                end else begin
                    state_n     = IDLE;
                    busy_n      = 1'b0;
                    drive_low_n = 1'b0;
                end
            end
            SLOT_ST: begin
                if (cnt == SAMP_LAST_C) begin
                    rx_n = {ow.bus_in, rx_q[7:1]};
                end
                if (cnt == SLOT_LAST_C) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n     = FIN;
                        done_n      = 1'b1;
                        busy_n      = 1'b0;
                        drive_low_n = 1'b0;
                    end else begin
                        bit_idx_n   = bit_idx + 3'd1;
                        shreg_n     = {1'b0, shreg[7:1]};
                        drive_low_n = ('0 < low_len(rw_q, shreg[1]));
                    end
                end else begin
                    cnt_n       = cnt + CW'(1);
                    drive_low_n = (cnt_n < low_len(rw_q, shreg[0]));
                end
            end
            default: begin
                state_n     = IDLE;
                busy_n      = 1'b0;
                drive_low_n = 1'b0;
            end
        endcase
    end

    assign ow.drive_low = drive_low_q;
    assign ow.busy      = busy_q;
    assign ow.done      = done_q;
    assign ow.rx_byte   = rx_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_onewire_byte_engine.sv
// Bench for onewire_byte_engine: pulse-width/spacing monitor, bus models and a done scoreboard.
module tb_onewire_byte_engine;
    localparam int PER        = 10;
    localparam int LOW1       = 162;
    localparam int LOW0       = 1620;
    localparam int SLOT       = 1890;
    localparam int BYTE_CYC   = 8 * SLOT;
    localparam int SLAVE_HOLD = 30 * 27;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    onewire_byte_engine_if ow();

    always #(PER/2) clk = ~clk;

    onewire_byte_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ow        (ow),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [15:0] exp_w_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [63:0] exp_done_q[$];

    // bus_mode 0: plain pull-up echo, 1: shorted low, 2: slave presenting slave_byte
    logic [1:0] bus_mode = 2'd0;
    logic [7:0] slave_byte = 8'h3C;
    int         slave_left = 0;

    assign ow.bus_in = (bus_mode == 2'd1) ? 1'b0 : ~(ow.drive_low | (slave_left != 0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pulse widths, slot spacing, slave reply, done scoreboard.
    logic   dl_prev = 1'b0;
    longint cyc = 0;
    longint p_start = 0;
    int     pulse_n = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (slave_left != 0) slave_left--;
            if (ow.drive_low && !dl_prev) begin
                if ((pulse_n % 8) != 0) chk("spacing", cyc - p_start, SLOT);
                if (bus_mode == 2'd2 && !slave_byte[pulse_n % 8]) slave_left = SLAVE_HOLD;
                p_start = cyc;
                pulse_n++;
            end
            if (!ow.drive_low && dl_prev && rst_n) begin
                if (exp_w_q.size() == 0) chk("width_unexp", exp_w_q.size(), 1);
                else chk("width", cyc - p_start, exp_w_q.pop_front());
            end
            if (ow.done) begin
                done_cnt++;
                chk("busy_at_done", ow.busy, 0);
                if (exp_rx_q.size() == 0) chk("done_unexp", exp_rx_q.size(), 1);
                else chk("rx_byte", ow.rx_byte, exp_rx_q.pop_front());
                if (exp_done_q.size() != 0) chk("done_time", $time - PER/2, exp_done_q.pop_front());
            end
            dl_prev = ow.drive_low;
        end
    end

    task automatic push_byte(input logic r, input logic [7:0] tx, input logic [7:0] rx_exp);
        for (int i = 0; i < 8; i++)
            exp_w_q.push_back((!r && !tx[i]) ? 16'(LOW0) : 16'(LOW1));
        exp_rx_q.push_back(rx_exp);
    endtask

    task automatic start_byte(input logic r, input logic [7:0] tx, input logic [7:0] rx_exp,
                              input logic hold);
        @(negedge clk);
        ow.start = 1'b1;
        ow.rw = r;
        ow.tx_byte = tx;
        push_byte(r, tx, rx_exp);
        @(posedge clk);
        exp_done_q.push_back($time + BYTE_CYC * PER);
        @(negedge clk);
        if (!hold) ow.start = 1'b0;
        chk("first_low", ow.drive_low, 1);
        chk("busy_on", ow.busy, 1);
    endtask

    task automatic wait_done();
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < BYTE_CYC + 100 && !seen) begin
            @(negedge clk);
            if (ow.done) seen = 1'b1;
            n++;
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        logic any_act;
        ow.start = 1'b0;
        ow.rw = 1'b0;
        ow.tx_byte = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_drive_low", ow.drive_low, 0);
        chk("rst_busy", ow.busy, 0);
        chk("rst_done", ow.done, 0);
        chk("rst_rx", ow.rx_byte, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", ow.busy, 0);

        // Write 0xA5 with echo bus; re-pulsed start in slot 3 must be ignored.
        bus_mode = 2'd0;
        start_byte(1'b0, 8'hA5, 8'hA5, 1'b0);
        repeat (2 * SLOT + 500) @(negedge clk);
        ow.start = 1'b1;
        ow.tx_byte = 8'h00;
        @(negedge clk);
        ow.start = 1'b0;
        chk("busy_mid", ow.busy, 1);
        wait_done();
        @(negedge clk);
        chk("done_cnt_a", done_cnt, 1);

        // Write 0xFF on shorted bus with start held into FIN, then a read of 0x3C.
        repeat (10) @(negedge clk);
        bus_mode = 2'd1;
        start_byte(1'b0, 8'hFF, 8'h00, 1'b1);
        ow.rw = 1'b1;
        ow.tx_byte = 8'h5A;
        wait_done();
        chk("fin_release", ow.drive_low, 0);
        push_byte(1'b1, 8'h5A, 8'h3C);
        bus_mode = 2'd2;
        @(posedge clk);
        exp_done_q.push_back($time + BYTE_CYC * PER);
        @(negedge clk);
        ow.start = 1'b0;
        chk("b2b_first_low", ow.drive_low, 1);
        chk("b2b_busy", ow.busy, 1);
        wait_done();
        @(negedge clk);
        chk("done_cnt_c", done_cnt, 3);

        // Write 0x00 and reset during the low phase of bit 2.
        repeat (10) @(negedge clk);
        bus_mode = 2'd0;
        @(negedge clk);
        ow.start = 1'b1;
        ow.rw = 1'b0;
        ow.tx_byte = 8'h00;
        exp_w_q.push_back(16'(LOW0));
        exp_w_q.push_back(16'(LOW0));
        @(negedge clk);
        ow.start = 1'b0;
        repeat (2 * SLOT + 300) @(negedge clk);
        chk("pre_rst_low", ow.drive_low, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_drive_low", ow.drive_low, 0);
        chk("async_busy", ow.busy, 0);
        chk("async_done", ow.done, 0);
        chk("async_state", state_dbg, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        any_act = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            any_act = any_act | ow.busy | ow.drive_low | ow.done | (state_dbg != 2'd0);
        end
        chk("idle_after_rst", any_act, 0);

        chk("done_total", done_cnt, 3);
        chk("w_q_empty", exp_w_q.size(), 0);
        chk("rx_q_empty", exp_rx_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
